// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg
// Shared definitions for the gated core clock controller.
//   - Command opcodes carried on cmd_op.
//   - Controller state encoding (RUN, HALT, STEP).
package clk_ctrl_pkg;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } gate_state_t;

endpackage

// File: rtl/clk_ctrl_cycle_counter.sv
// clk_ctrl_cycle_counter
// Free-running up-counter of delivered gated cycles.
// Ports:
//   clk_in  - free-running clock
//   resetn  - asynchronous active-low reset
//   inc     - count this cycle
//   clear   - synchronous clear, wins over inc
//   count   - current count, wraps modulo 2^CNT_WIDTH
module clk_ctrl_cycle_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 resetn,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    // Clear has priority so a clear during an enabled cycle reads back as 0.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
// Produces the clock-enable for the gated core clock buffer. A host can run,
// halt or single-step the gated clock by an exact number of cycles, and a
// force_halt input stops it immediately for fault handling.
// Ports:
//   clk_in       - free-running clock (same clock feeding the gated buffer)
//   resetn       - asynchronous active-low reset
//   cmd_valid    - command request
//   cmd_ready    - controller can accept a command
//   cmd_op       - 00 RUN, 01 HALT, 10 STEP, 11 reserved (no effect)
//   cmd_steps    - STEP cycle count, sampled on acceptance
//   force_halt   - level, overrides everything and blocks commands
//   cnt_clear    - synchronous clear of gated_cycles
//   enable       - CE to the gated clock buffer, straight from a flop
//   halted       - high while in HALT
//   step_done    - one-cycle pulse when a STEP completes
//   gated_cycles - count of cycles with enable high, wrapping
module clk_gate_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH     = 32,
    parameter bit RESET_RUNNING = 1'b1
) (
    input  logic                 clk_in,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_WIDTH-1:0] cmd_steps,
    input  logic                 force_halt,
    input  logic                 cnt_clear,
    output logic                 enable,
    output logic                 halted,
    output logic                 step_done,
    output logic [CNT_WIDTH-1:0] gated_cycles
);

    localparam gate_state_t          RESET_STATE = RESET_RUNNING ? RUN : HALT;
    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

    gate_state_t          state, state_next;
    logic                 enable_next;
    logic                 step_done_next;
    logic [CNT_WIDTH-1:0] remaining, remaining_next;
    logic                 zero_step_pend, zero_step_pend_next;
    logic                 cmd_accept;

    assign cmd_ready  = (state != STEP) && !force_halt;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign halted     = (state == HALT);

    // All outputs that reach the clock buffer come from these flops so the
    // CE never glitches.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state          <= RESET_STATE;
            enable         <= RESET_RUNNING;
            step_done      <= 1'b0;
            remaining      <= '0;
            zero_step_pend <= 1'b0;
        end else begin
            state          <= state_next;
            enable         <= enable_next;
            step_done      <= step_done_next;
            remaining      <= remaining_next;
            zero_step_pend <= zero_step_pend_next;
        end
    end

    // Priority: force_halt, then an in-flight STEP, then a new command.
    // A zero-length STEP halts at once and reports done one cycle later via
    // zero_step_pend.
    always_comb begin
        state_next          = state;
        enable_next         = enable;
        remaining_next      = remaining;
        step_done_next      = zero_step_pend;
        zero_step_pend_next = 1'b0;

        if (force_halt) begin
            state_next     = HALT;
            enable_next    = 1'b0;
            remaining_next = '0;
        end else if (state == STEP) begin
            remaining_next = remaining - ONE;
            if (remaining == ONE) begin
                state_next     = HALT;
                enable_next    = 1'b0;
                step_done_next = 1'b1;
            end
        end else if (cmd_accept) begin
            case (cmd_op)
                OP_RUN: begin
                    state_next  = RUN;
                    enable_next = 1'b1;
                end
                OP_HALT: begin
                    state_next  = HALT;
                    enable_next = 1'b0;
                end
                OP_STEP: begin
                    if (cmd_steps != '0) begin
                        state_next     = STEP;
                        enable_next    = 1'b1;
                        remaining_next = cmd_steps;
                    end else begin
                        state_next          = HALT;
                        enable_next         = 1'b0;
                        zero_step_pend_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    clk_ctrl_cycle_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cycle_counter (
        .clk_in (clk_in),
        .resetn (resetn),
        .inc    (enable),
        .clear  (cnt_clear),
        .count  (gated_cycles)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
// Directed bench for clk_gate_ctrl. Three instances share clock and reset:
// the main one starts halted, one starts running, and a 4-bit one exercises
// counter wrap and clear.
module tb_clk_gate_ctrl;

    logic        clk_in = 1'b0;
    logic        resetn = 1'b0;

    logic        cmd_valid = 1'b0, cmd_ready, force_halt = 1'b0, cnt_clear = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_steps = '0, gated_cycles;
    logic        enable, halted, step_done;

    logic        r_cmd_ready, r_enable, r_halted, r_step_done;
    logic [31:0] r_gated_cycles;

    logic        s_cnt_clear = 1'b0, s_cmd_ready, s_enable, s_halted, s_step_done;
    logic [3:0]  s_gated_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    clk_gate_ctrl #(.CNT_WIDTH(32), .RESET_RUNNING(1'b0)) dut (
        .clk_in(clk_in), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .force_halt(force_halt), .cnt_clear(cnt_clear),
        .enable(enable), .halted(halted), .step_done(step_done), .gated_cycles(gated_cycles)
    );

    clk_gate_ctrl #(.CNT_WIDTH(32), .RESET_RUNNING(1'b1)) dut_run (
        .clk_in(clk_in), .resetn(resetn), .cmd_valid(1'b0), .cmd_ready(r_cmd_ready),
        .cmd_op(2'b00), .cmd_steps(32'd0), .force_halt(1'b0), .cnt_clear(1'b0),
        .enable(r_enable), .halted(r_halted), .step_done(r_step_done), .gated_cycles(r_gated_cycles)
    );

    clk_gate_ctrl #(.CNT_WIDTH(4), .RESET_RUNNING(1'b1)) dut_small (
        .clk_in(clk_in), .resetn(resetn), .cmd_valid(1'b0), .cmd_ready(s_cmd_ready),
        .cmd_op(2'b00), .cmd_steps(4'd0), .force_halt(1'b0), .cnt_clear(s_cnt_clear),
        .enable(s_enable), .halted(s_halted), .step_done(s_step_done), .gated_cycles(s_gated_cycles)
    );

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (r_enable !== 1'b1) begin errors++; $display("[TB] FAIL reset_run_enable got %0b want 1", r_enable); end
        checks++; if (r_halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_run_halted got %0b want 0", r_halted); end
        checks++; if (r_gated_cycles !== 32'd10) begin errors++; $display("[TB] FAIL reset_run_count got %0d want 10", r_gated_cycles); end
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt_enable got %0b want 0", enable); end
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL reset_halt_halted got %0b want 1", halted); end
        checks++; if (gated_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_halt_count got %0d want 0", gated_cycles); end
        checks++; if (cmd_ready !== 1'b1 || step_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_done got %0b/%0b want 1/0", cmd_ready, step_done); end
    endtask

    task automatic test_step();
        int high_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 32'd5;
        tick();
        cmd_valid = 1'b0;
        checks++; if (enable !== 1'b1 || cmd_ready !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL step_start en/ready/halted got %0b/%0b/%0b want 1/0/0", enable, cmd_ready, halted); end
        high_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (enable === 1'b1) high_cnt++;
            checks++; if (step_done !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL step_mid%0d done/ready got %0b/%0b want 0/0", i, step_done, cmd_ready); end
        end
        checks++; if (high_cnt != 5) begin errors++; $display("[TB] FAIL step_enable_cycles got %0d want 5", high_cnt); end
        tick();
        checks++; if (enable !== 1'b0 || step_done !== 1'b1 || halted !== 1'b1) begin errors++; $display("[TB] FAIL step_end en/done/halted got %0b/%0b/%0b want 0/1/1", enable, step_done, halted); end
        checks++; if (gated_cycles !== 32'd5) begin errors++; $display("[TB] FAIL step_count got %0d want 5", gated_cycles); end
        tick();
        checks++; if (step_done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL step_after done/ready got %0b/%0b want 0/1", step_done, cmd_ready); end
    endtask

    task automatic test_zero_step();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 32'd0;
        tick();
        cmd_valid = 1'b0;
        checks++; if (enable !== 1'b0 || step_done !== 1'b0 || halted !== 1'b1) begin errors++; $display("[TB] FAIL zero_accept en/done/halted got %0b/%0b/%0b want 0/0/1", enable, step_done, halted); end
        tick();
        checks++; if (enable !== 1'b0 || step_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done en/done got %0b/%0b want 0/1", enable, step_done); end
        tick();
        checks++; if (step_done !== 1'b0 || halted !== 1'b1 || gated_cycles !== 32'd5) begin errors++; $display("[TB] FAIL zero_after done/halted/count got %0b/%0b/%0d want 0/1/5", step_done, halted, gated_cycles); end
    endtask

    task automatic test_run_then_step();
        cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        cmd_valid = 1'b0;
        checks++; if (enable !== 1'b1 || halted !== 1'b0) begin errors++; $display("[TB] FAIL run_start en/halted got %0b/%0b want 1/0", enable, halted); end
        tick();
        tick();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 32'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (enable !== 1'b1 || step_done !== 1'b0) begin errors++; $display("[TB] FAIL run_step_mid%0d en/done got %0b/%0b want 1/0", i, enable, step_done); end
        end
        tick();
        checks++; if (enable !== 1'b0 || step_done !== 1'b1 || halted !== 1'b1) begin errors++; $display("[TB] FAIL run_step_end en/done/halted got %0b/%0b/%0b want 0/1/1", enable, step_done, halted); end
        checks++; if (gated_cycles !== 32'd11) begin errors++; $display("[TB] FAIL run_step_count got %0d want 11", gated_cycles); end
        cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        checks++; if (enable !== 1'b1 || gated_cycles !== 32'd11) begin errors++; $display("[TB] FAIL rerun en/count got %0b/%0d want 1/11", enable, gated_cycles); end
        cmd_op = 2'b01;
        tick();
        cmd_valid = 1'b0;
        checks++; if (enable !== 1'b0 || halted !== 1'b1 || gated_cycles !== 32'd12) begin errors++; $display("[TB] FAIL halt_cmd en/halted/count got %0b/%0b/%0d want 0/1/12", enable, halted, gated_cycles); end
    endtask

    task automatic test_force_halt();
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 32'd100;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        checks++; if (enable !== 1'b1 || gated_cycles !== 32'd51) begin errors++; $display("[TB] FAIL force_pre en/count got %0b/%0d want 1/51", enable, gated_cycles); end
        force_halt = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL force_ready got %0b want 0", cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (enable !== 1'b0 || step_done !== 1'b0 || halted !== 1'b1) begin errors++; $display("[TB] FAIL force_hold%0d en/done/halted got %0b/%0b/%0b want 0/0/1", i, enable, step_done, halted); end
        end
        force_halt = 1'b0; cmd_valid = 1'b0;
        tick();
        checks++; if (enable !== 1'b0 || halted !== 1'b1 || step_done !== 1'b0) begin errors++; $display("[TB] FAIL force_release en/halted/done got %0b/%0b/%0b want 0/1/0", enable, halted, step_done); end
        checks++; if (gated_cycles !== 32'd52) begin errors++; $display("[TB] FAIL force_count got %0d want 52", gated_cycles); end
    endtask

    task automatic test_wrap();
        s_cnt_clear = 1'b1;
        tick();
        s_cnt_clear = 1'b0;
        checks++; if (s_gated_cycles !== 4'd0) begin errors++; $display("[TB] FAIL wrap_clear0 got %0d want 0", s_gated_cycles); end
        for (int i = 0; i < 18; i++) tick();
        checks++; if (s_gated_cycles !== 4'd2) begin errors++; $display("[TB] FAIL wrap_count got %0d want 2", s_gated_cycles); end
        s_cnt_clear = 1'b1;
        tick();
        s_cnt_clear = 1'b0;
        checks++; if (s_gated_cycles !== 4'd0 || s_enable !== 1'b1) begin errors++; $display("[TB] FAIL wrap_clear count/en got %0d/%0b want 0/1", s_gated_cycles, s_enable); end
        tick();
        checks++; if (s_gated_cycles !== 4'd1) begin errors++; $display("[TB] FAIL wrap_resume got %0d want 1", s_gated_cycles); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_zero_step();
        test_run_then_step();
        test_force_halt();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
